// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Purpose  : EX-stage ALU. ADD/SUB/AND/OR/XOR complete in one cycle.
//            SLL/SRL (and SRA when ALU_SRA_EN is defined) shift 1 bit per
//            cycle. Valid/ready handshake on both request and result.
// Config   : ALU_SRA_EN defined   -> alu_control 111 = arithmetic right shift
//            ALU_SRA_EN undefined -> alu_control 111 = illegal
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready, alu_control[2:0], op_a, op_b  (request)
//            out_valid/out_ready, result, zero, illegal       (response)
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      alu_control,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SRL = 3'b101;
   localparam logic [2:0] OP_SLL = 3'b110;
   localparam logic [2:0] OP_SRA = 3'b111;

   localparam logic [1:0] K_SLL = 2'd0;
   localparam logic [1:0] K_SRL = 2'd1;
   localparam logic [1:0] K_SRA = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t               state;
   logic [SHAMT_W-1:0]   cnt;
   logic [1:0]           kind;

   // Decode of the request as presented in the accept cycle.
   logic [XLEN-1:0]      acc_result;
   logic                 acc_shift;
   logic [1:0]           acc_kind;
   logic                 acc_bad;
   logic [SHAMT_W-1:0]   shamt;

   // One-bit step of the working register (result doubles as the shifter).
   logic [XLEN-1:0]      shifted;

   assign shamt = op_b[SHAMT_W-1:0];

   always_comb begin
      acc_result = '0;
      acc_shift  = 1'b0;
      acc_kind   = K_SLL;
      acc_bad    = 1'b0;
      // X/Z codes match no item in 4-state simulation and land in default.
      case (alu_control)
         OP_ADD: acc_result = op_a + op_b;
         OP_SUB: acc_result = op_a - op_b;
         OP_AND: acc_result = op_a & op_b;
         OP_OR:  acc_result = op_a | op_b;
         OP_XOR: acc_result = op_a ^ op_b;
         OP_SRL: begin
            acc_result = op_a;
            acc_shift  = 1'b1;
            acc_kind   = K_SRL;
         end
         OP_SLL: begin
            acc_result = op_a;
            acc_shift  = 1'b1;
            acc_kind   = K_SLL;
         end
         OP_SRA: begin
`ifdef ALU_SRA_EN
            acc_result = op_a;
            acc_shift  = 1'b1;
            acc_kind   = K_SRA;
`else
            acc_bad    = 1'b1;
`endif
         end
         default: acc_bad = 1'b1;
      endcase
   end

   always_comb begin
      case (kind)
         K_SLL:   shifted = {result[XLEN-2:0], 1'b0};
         K_SRL:   shifted = {1'b0, result[XLEN-1:1]};
         default: shifted = {result[XLEN-1], result[XLEN-1:1]};
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         illegal   <= 1'b0;
         cnt       <= '0;
         kind      <= K_SLL;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  result   <= acc_result;
                  illegal  <= acc_bad;
                  kind     <= acc_kind;
                  cnt      <= shamt;
                  in_ready <= 1'b0;
                  // A zero shift amount needs no iteration: finish now.
                  if (acc_shift && (shamt != '0)) begin
                     state <= S_SHIFT;
                  end else begin
                     state     <= S_DONE;
                     out_valid <= 1'b1;
                     zero      <= ~|acc_result;
                  end
               end
            end
            S_SHIFT: begin
               result <= shifted;
               cnt    <= cnt - SHAMT_W'(1);
               if (cnt == SHAMT_W'(1)) begin
                  state     <= S_DONE;
                  out_valid <= 1'b1;
                  zero      <= ~|shifted;
               end
            end
            S_DONE: begin
               // in_ready rises only once back in IDLE, so no accept can
               // coincide with the result handshake.
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= S_IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
